// File: rtl/wb_pkg.sv
// Shared constants and types for the write-back stage.
package wb_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    LD_WORD = 2'b00,
    LD_HALF = 2'b01,
    LD_BYTE = 2'b10,
    LD_RSVD = 2'b11
  } ld_size_e;

  localparam logic WB_SRC_ALU = 1'b0;
  localparam logic WB_SRC_MEM = 1'b1;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load formatter: lane select, sign/zero extension, alignment check.
module wb_load_align
  import wb_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        addr,
  input  ld_size_e          size,
  input  logic              sign,
  output logic [DATA_W-1:0] data_c,
  output logic              mis_c
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  // Halfword lane ignores addr[0]; a misaligned halfword still reads its lane.
  assign lane8  = data[{addr, 3'b000} +: 8];
  assign lane16 = data[{addr[1], 4'b0000} +: 16];

  always_comb begin
    data_c = data;
    mis_c  = 1'b0;
    unique case (size)
      LD_HALF: begin
        data_c = {{16{sign & lane16[15]}}, lane16};
        mis_c  = addr[0];
      end
      LD_BYTE: begin
        data_c = {{24{sign & lane8[7]}}, lane8};
        mis_c  = 1'b0;
      end
      default: begin
        data_c = data;
        mis_c  = (addr != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: source mux with combinational bypass value and registered
// register-file write request.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              DataInputS,
  input  logic [DATA_W-1:0] Data5,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              reg_we_i,
  input  logic [1:0]        ld_size_i,
  input  logic              ld_signed_i,
  output logic [DATA_W-1:0] DataInput,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic              valid_o,
  output logic              misalign_o
);

  logic [DATA_W-1:0] ld_data;
  logic              ld_mis;
  logic              mis;

  wb_load_align u_align (
    .data   (Data5),
    .addr   (ALUResult[1:0]),
    .size   (ld_size_e'(ld_size_i)),
    .sign   (ld_signed_i),
    .data_c (ld_data),
    .mis_c  (ld_mis)
  );

  // Alignment only matters when the value actually comes from memory.
  assign mis       = (DataInputS == WB_SRC_MEM) & ld_mis;
  assign DataInput = (DataInputS == WB_SRC_MEM) ? ld_data : ALUResult;

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      valid_o    <= 1'b0;
      misalign_o <= 1'b0;
    end else if (!stall_i) begin
      rf_we_o    <= valid_i & reg_we_i & ~mis;
      rf_waddr_o <= rd_i;
      rf_wdata_o <= DataInput;
      valid_o    <= valid_i;
      misalign_o <= valid_i & mis;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed and randomized bench for wb_stage against a behavioural model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        stall_i;
  logic        DataInputS;
  logic [31:0] Data5;
  logic [31:0] ALUResult;
  logic [3:0]  rd_i;
  logic        reg_we_i;
  logic [1:0]  ld_size_i;
  logic        ld_signed_i;
  logic [31:0] DataInput;
  logic        rf_we_o;
  logic [3:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        valid_o;
  logic        misalign_o;

  int total = 0;
  int bad   = 0;

  logic        e_we, e_valid, e_mis;
  logic [3:0]  e_addr;
  logic [31:0] e_data;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .stall_i(stall_i),
    .DataInputS(DataInputS), .Data5(Data5), .ALUResult(ALUResult),
    .rd_i(rd_i), .reg_we_i(reg_we_i), .ld_size_i(ld_size_i),
    .ld_signed_i(ld_signed_i), .DataInput(DataInput), .rf_we_o(rf_we_o),
    .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .valid_o(valid_o),
    .misalign_o(misalign_o)
  );

  // Reference: shift the addressed lane down, mask, then extend arithmetically.
  function automatic logic [31:0] fmt_m(input logic [31:0] d, input logic [31:0] adr,
                                        input logic [1:0] sz, input logic sg);
    int unsigned a;
    logic [31:0] v;
    a = adr % 4;
    if (sz == 2'd1) begin
      v = (d >> (16 * (a / 2))) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v - 32'h10000;
    end else if (sz == 2'd2) begin
      v = (d >> (8 * a)) & 32'hFF;
      if (sg && v >= 32'h80) v = v - 32'h100;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic logic mis_m();
    int unsigned a;
    a = ALUResult % 4;
    if (!DataInputS) return 1'b0;
    if (ld_size_i == 2'd1) return (a % 2) == 1;
    if (ld_size_i == 2'd2) return 1'b0;
    return a != 0;
  endfunction

  function automatic logic [31:0] di_m();
    return DataInputS ? fmt_m(Data5, ALUResult, ld_size_i, ld_signed_i) : ALUResult;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic comb(input string tag);
    #1;
    check({tag, "_di"}, DataInput, di_m());
  endtask

  // Advance one edge, updating and checking the expected registered state.
  task automatic tick(input string tag);
    if (rst) begin
      e_we = 0; e_valid = 0; e_mis = 0; e_addr = 0; e_data = 0;
    end else if (!stall_i) begin
      e_valid = valid_i;
      e_we    = valid_i & reg_we_i & ~mis_m();
      e_mis   = valid_i & mis_m();
      e_addr  = rd_i;
      e_data  = di_m();
    end
    @(posedge clk);
    #1;
    check({tag, "_we"},    32'(rf_we_o),    32'(e_we));
    check({tag, "_waddr"}, 32'(rf_waddr_o), 32'(e_addr));
    check({tag, "_wdata"}, rf_wdata_o,      e_data);
    check({tag, "_valid"}, 32'(valid_o),    32'(e_valid));
    check({tag, "_mis"},   32'(misalign_o), 32'(e_mis));
  endtask

  initial begin
    rst = 1; valid_i = 0; stall_i = 0; DataInputS = 0; Data5 = 0; ALUResult = 0;
    rd_i = 0; reg_we_i = 0; ld_size_i = 0; ld_signed_i = 0;
    @(posedge clk); #1;
    tick("reset");
    check("reset_we_const", 32'(rf_we_o), 32'd0);
    rst = 0;

    // Source select, zero latency
    Data5 = 3; ALUResult = 5; DataInputS = 0; #1;
    check("sel_alu", DataInput, 32'd5);
    DataInputS = 1; ld_size_i = 2'b00; #1;
    check("sel_mem", DataInput, 32'd3);
    Data5 = 0; ALUResult = 0; #1;
    check("sel_zero", DataInput, 32'd0);

    // Byte loads
    Data5 = 32'h80FF7F01; ALUResult = 32'h1003; ld_size_i = 2'b10; ld_signed_i = 1; #1;
    check("byte3_s", DataInput, 32'hFFFFFF80);
    ld_signed_i = 0; #1;
    check("byte3_u", DataInput, 32'h00000080);
    ALUResult = 32'h1001; ld_signed_i = 1; #1;
    check("byte1_s", DataInput, 32'h0000007F);

    // Halfword loads, aligned and misaligned
    Data5 = 32'h80017FFE; ALUResult = 32'h2002; ld_size_i = 2'b01; #1;
    check("half2_s", DataInput, 32'hFFFF8001);
    valid_i = 1; reg_we_i = 1; rd_i = 3; ALUResult = 32'h2001;
    comb("half1");
    tick("half_mis");
    check("half_mis_flag", 32'(misalign_o), 32'd1);
    check("half_mis_we", 32'(rf_we_o), 32'd0);

    // Reserved size behaves like word, alignment included
    ld_size_i = 2'b11; ALUResult = 32'h2002;
    comb("rsvd");
    tick("rsvd");

    // Plain ALU write, then stall hold
    DataInputS = 0; rd_i = 7; ALUResult = 32'h1234;
    comb("alu_wr");
    tick("alu_wr");
    check("alu_wr_data", rf_wdata_o, 32'h1234);
    check("alu_wr_addr", 32'(rf_waddr_o), 32'd7);
    stall_i = 1; rd_i = 2; ALUResult = 32'hBEEF; valid_i = 0;
    tick("stall");
    check("stall_hold", rf_wdata_o, 32'h1234);
    stall_i = 0;
    tick("idle");

    // Reset discards in-flight write; bypass still live
    valid_i = 1; reg_we_i = 1; rd_i = 9; ALUResult = 32'h55AA;
    tick("pre_rst");
    rst = 1; ALUResult = 32'h77;
    comb("in_rst");
    tick("rst");
    check("rst_data", rf_wdata_o, 32'd0);
    rst = 0;

    // Randomized sweep
    for (int i = 0; i < 300; i++) begin
      rst         = ($urandom_range(0, 15) == 0);
      stall_i     = ($urandom_range(0, 3) == 0);
      valid_i     = 1'($urandom);
      reg_we_i    = 1'($urandom);
      DataInputS  = 1'($urandom);
      Data5       = $urandom;
      ALUResult   = $urandom;
      rd_i        = 4'($urandom);
      ld_size_i   = 2'($urandom);
      ld_signed_i = 1'($urandom);
      comb("rnd");
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
